// File: rtl/serial_tx_framer_pkg.sv
// Shared definitions for the serial transmit path: FSM states, line levels and
// the default word/baud sizing used by the controller and the receive side.
package serial_tx_framer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE
  } tx_state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_BAUD_DIV   = 4;

  // True for every state in which a bit is being driven onto the line.
  function automatic logic frame_is_busy(input tx_state_e s);
    return (s == START) || (s == DATA) || (s == PARITY) || (s == STOP);
  endfunction

endpackage

// File: rtl/serial_tx_framer_if.sv
// Handshake between the read/write flow controller (master) and the
// transmit framer (slave), plus the serial line and status back to the controller.
interface serial_tx_framer_if #(
  parameter int unsigned DATA_WIDTH = serial_tx_framer_pkg::DEF_DATA_WIDTH
);

  logic                  SampleData;
  logic [DATA_WIDTH-1:0] DataIn;
  logic                  TransferData;
  logic                  TxOut;
  logic                  TxBusy;
  logic                  TransferDone;

  modport master (
    output SampleData,
    output DataIn,
    output TransferData,
    input  TxOut,
    input  TxBusy,
    input  TransferDone
  );

  modport slave (
    input  SampleData,
    input  DataIn,
    input  TransferData,
    output TxOut,
    output TxBusy,
    output TransferDone
  );

endinterface

// File: rtl/serial_tx_framer_tx_baud_counter.sv
// Bit-period timer: counts while enabled and flags the last cycle of each
// BAUD_DIV-cycle bit period. Held at zero whenever disabled.
module tx_baud_counter #(
  parameter int unsigned BAUD_DIV = serial_tx_framer_pkg::DEF_BAUD_DIV
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Enable,
  output logic Tick
);

  logic [7:0] count;

  assign Tick = Enable && (count == 8'(BAUD_DIV - 1));

  // Free-running period counter, restarted on every tick or when idle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (!Enable || Tick) begin
      count <= '0;
    end else begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/serial_tx_framer.sv
// Parallel-to-serial transmit framer. Captures a word on SampleData while idle,
// sends start / data LSB-first / optional even parity / stop on TransferData,
// and pulses TransferDone for one cycle when the frame has left the line.
module serial_tx_framer
  import serial_tx_framer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned BAUD_DIV   = DEF_BAUD_DIV,
  parameter int unsigned PARITY_EN  = 0
) (
  input logic              Clk,
  input logic              Reset,
  serial_tx_framer_if.slave bus
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  tx_state_e             state, next_state;
  logic                  tx_out, next_tx;
  logic                  tx_busy;
  logic                  transfer_done;
  logic [DATA_WIDTH-1:0] hold_reg;
  logic                  loaded;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic                  parity_acc, parity_next;
  logic [CNT_W-1:0]      bit_cnt, cnt_next;
  logic                  tick;
  logic                  go;

  // A word captured in the same idle cycle counts as loaded for the start decision.
  assign go = bus.TransferData && (loaded || bus.SampleData);

  tx_baud_counter #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud (
    .Clk   (Clk),
    .Reset (Reset),
    .Enable(frame_is_busy(state)),
    .Tick  (tick)
  );

  // Next state plus the line level and datapath values for the next cycle.
  // The line bit is chosen from the upcoming state so TxOut stays a flop.
  always_comb begin
    next_state  = state;
    next_tx     = tx_out;
    shift_next  = shift_reg;
    parity_next = parity_acc;
    cnt_next    = bit_cnt;
    unique case (state)
      IDLE: begin
        if (go) begin
          next_state  = START;
          next_tx     = START_BIT;
          shift_next  = bus.SampleData ? bus.DataIn : hold_reg;
          parity_next = 1'b0;
          cnt_next    = '0;
        end
      end
      START: begin
        if (tick) begin
          next_state = DATA;
          next_tx    = shift_reg[0];
        end
      end
      DATA: begin
        if (tick) begin
          parity_next = parity_acc ^ shift_reg[0];
          shift_next  = shift_reg >> 1;
          if (bit_cnt == LAST_BIT) begin
            cnt_next = '0;
            if (PARITY_EN != 0) begin
              next_state = PARITY;
              next_tx    = parity_next;
            end else begin
              next_state = STOP;
              next_tx    = STOP_BIT;
            end
          end else begin
            cnt_next = bit_cnt + 1'b1;
            next_tx  = shift_next[0];
          end
        end
      end
      PARITY: begin
        if (tick) begin
          next_state = STOP;
          next_tx    = STOP_BIT;
        end
      end
      STOP: begin
        if (tick) begin
          next_state = DONE;
          next_tx    = LINE_IDLE;
        end
      end
      DONE: begin
        next_state = IDLE;
        next_tx    = LINE_IDLE;
      end
      default: begin
        next_state = IDLE;
        next_tx    = LINE_IDLE;
      end
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state         <= IDLE;
      tx_out        <= LINE_IDLE;
      tx_busy       <= 1'b0;
      transfer_done <= 1'b0;
    end else begin
      state         <= next_state;
      tx_out        <= next_tx;
      tx_busy       <= frame_is_busy(next_state);
      transfer_done <= (next_state == DONE);
    end
  end

  // Holding register: captures only while idle so an in-flight frame is untouched.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hold_reg <= '0;
      loaded   <= 1'b0;
    end else if (state == IDLE && bus.SampleData) begin
      hold_reg <= bus.DataIn;
      loaded   <= 1'b1;
    end else if (state == DONE) begin
      loaded   <= 1'b0;
    end
  end

  // Shift register, parity accumulator and bit counter.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      shift_reg  <= '0;
      parity_acc <= 1'b0;
      bit_cnt    <= '0;
    end else begin
      shift_reg  <= shift_next;
      parity_acc <= parity_next;
      bit_cnt    <= cnt_next;
    end
  end

  assign bus.TxOut        = tx_out;
  assign bus.TxBusy       = tx_busy;
  assign bus.TransferDone = transfer_done;

endmodule

// File: tb/tb_serial_tx_framer.sv
// Directed bench for serial_tx_framer: one instance without parity, one with.
module tb_serial_tx_framer;

  localparam int unsigned W = 8;
  localparam int unsigned B = 4;

  logic Clk = 1'b0;
  logic Reset;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clk = ~Clk;

  serial_tx_framer_if #(.DATA_WIDTH(W)) bus0 ();
  serial_tx_framer_if #(.DATA_WIDTH(W)) bus1 ();

  serial_tx_framer #(
    .DATA_WIDTH(W),
    .BAUD_DIV  (B),
    .PARITY_EN (0)
  ) u_dut0 (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus0)
  );

  serial_tx_framer #(
    .DATA_WIDTH(W),
    .BAUD_DIV  (B),
    .PARITY_EN (1)
  ) u_dut1 (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int sel, input logic sd, input logic [W-1:0] din, input logic td);
    if (sel == 0) begin
      bus0.SampleData = sd; bus0.DataIn = din; bus0.TransferData = td;
    end else begin
      bus1.SampleData = sd; bus1.DataIn = din; bus1.TransferData = td;
    end
  endtask

  // {TransferDone, TxBusy, TxOut}
  function automatic logic [2:0] outs(input int sel);
    if (sel == 0) return {bus0.TransferDone, bus0.TxBusy, bus0.TxOut};
    return {bus1.TransferDone, bus1.TxBusy, bus1.TxOut};
  endfunction

  task automatic check_idle(input int sel, input int ncyc, input string tag);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge Clk);
      check($sformatf("%s idle dut%0d c%0d", tag, sel, i), 32'(outs(sel)), 32'h1);
    end
  endtask

  // Loads data (one cycle ahead, or in the same cycle when same_cycle),
  // fires TransferData, then checks every cycle of the frame and the done cycle.
  // TransferData stays high while k <= hold; a SampleData of inj_data is pushed at k == inj_k.
  task automatic run_frame(input int sel, input logic [W-1:0] data, input bit same_cycle,
                           input int hold, input int inj_k, input logic [W-1:0] inj_data,
                           input string tag);
    int nbits;
    int flen;
    logic [15:0] bits;
    logic [2:0] o;
    nbits = W + 2 + sel;
    flen  = nbits * B;
    bits  = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < W; i++) bits[i+1] = data[i];
    if (sel != 0) bits[W+1] = ^data;
    bits[nbits-1] = 1'b1;
    if (!same_cycle) begin
      @(negedge Clk);
      set_in(sel, 1'b1, data, 1'b0);
    end
    @(negedge Clk);
    set_in(sel, same_cycle, data, 1'b1);
    for (int k = 1; k <= flen + 1; k++) begin
      @(negedge Clk);
      o = outs(sel);
      if (k <= flen) begin
        check($sformatf("%s tx k=%0d", tag, k), 32'(o[0]), 32'(bits[(k-1)/B]));
        check($sformatf("%s busy k=%0d", tag, k), 32'(o[1]), 32'h1);
        check($sformatf("%s done k=%0d", tag, k), 32'(o[2]), 32'h0);
      end else begin
        check($sformatf("%s done-cycle", tag), 32'(o), 32'h5);
      end
      set_in(sel, (k == inj_k), (k == inj_k) ? inj_data : data, (k <= hold));
    end
  endtask

  initial begin
    Reset = 1'b1;
    set_in(0, 1'b0, '0, 1'b0);
    set_in(1, 1'b0, '0, 1'b0);

    // Reset held two cycles, outputs at reset values throughout and after.
    #1;
    check("reset dut0", 32'(outs(0)), 32'h1);
    check("reset dut1", 32'(outs(1)), 32'h1);
    repeat (2) begin
      @(negedge Clk);
      check("in-reset dut0", 32'(outs(0)), 32'h1);
      check("in-reset dut1", 32'(outs(1)), 32'h1);
    end
    Reset = 1'b0;
    check_idle(0, 5, "post-reset");
    check_idle(1, 5, "post-reset");

    // 0xA5 without parity: 0,1,0,1,0,0,1,0,1,1; done 41 cycles after acceptance.
    run_frame(0, 8'hA5, 1'b0, 0, 0, 8'h00, "A5");
    check_idle(0, 3, "after A5");

    // 0x07 with even parity: parity bit 1, 44-cycle frame, done at 45.
    run_frame(1, 8'h07, 1'b0, 0, 0, 8'h00, "07p");
    check_idle(1, 3, "after 07p");

    // TransferData with nothing loaded is ignored.
    @(negedge Clk);
    set_in(0, 1'b0, 8'h00, 1'b1);
    @(negedge Clk);
    set_in(0, 1'b0, 8'h00, 1'b0);
    check_idle(0, 6, "no-load");

    // SampleData 0x3C mid-frame must not alter the frame or leave a word loaded.
    run_frame(0, 8'h5A, 1'b0, 0, 10, 8'h3C, "5A-inj");
    @(negedge Clk);
    set_in(0, 1'b0, 8'h00, 1'b1);
    @(negedge Clk);
    set_in(0, 1'b0, 8'h00, 1'b0);
    check_idle(0, 8, "after inj");

    // TransferData held 60 cycles: one frame, no retrigger.
    run_frame(0, 8'h96, 1'b0, 60, 0, 8'h00, "96-hold");
    for (int k = 42; k <= 60; k++) begin
      @(negedge Clk);
      check($sformatf("hold no-retrigger k=%0d", k), 32'(outs(0)), 32'h1);
    end
    set_in(0, 1'b0, 8'h00, 1'b0);
    check_idle(0, 3, "hold released");

    // Reset during data bit 3 (frame bit 4 spans k=17..20).
    @(negedge Clk);
    set_in(0, 1'b1, 8'hA5, 1'b0);
    @(negedge Clk);
    set_in(0, 1'b0, 8'hA5, 1'b1);
    @(negedge Clk);
    set_in(0, 1'b0, 8'hA5, 1'b0);
    repeat (17) @(negedge Clk);
    check("pre-reset bit3", 32'(outs(0)), 32'h2);
    #2 Reset = 1'b1;
    #1;
    check("async reset outs", 32'(outs(0)), 32'h1);
    @(negedge Clk);
    Reset = 1'b0;
    check_idle(0, 12, "after mid reset");
    @(negedge Clk);
    set_in(0, 1'b0, 8'h00, 1'b1);
    @(negedge Clk);
    set_in(0, 1'b0, 8'h00, 1'b0);
    check_idle(0, 6, "loaded cleared");

    // Fresh frame after reset, sample and transfer in the same idle cycle.
    run_frame(0, 8'hC3, 1'b1, 0, 0, 8'h00, "C3-same");
    check_idle(0, 3, "after C3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
